// File: rtl/axis_hdr_pkg.sv
// ---------------------------------------------------------------------------
// axis_hdr_pkg
// Shared types and helpers for the header-insertion stream block.
//   state_e          : packet FSM states (IDLE, HDR, PAY, FLUSH)
//   popcount         : number of set bits in a keep vector
//   keep_lsb_contig  : keep is non-zero and a contiguous run starting at bit 0
//   keep_from_count  : MSB-aligned keep with n ones inside a w-bit field
// Keep vectors are passed zero-extended to KEEP_MAX bits so one function set
// serves every bus width up to KEEP_MAX bytes.
// ---------------------------------------------------------------------------
package axis_hdr_pkg;

    localparam int unsigned KEEP_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_PAY   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    function automatic int unsigned popcount(input logic [KEEP_MAX-1:0] k);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            n = n + 32'(k[i]);
        end
        return n;
    endfunction

    // A run of ones anchored at bit 0 plus one is a power of two, so AND-ing
    // it with the original clears every bit. One spare bit absorbs the carry
    // out of an all-ones vector.
    function automatic logic keep_lsb_contig(input logic [KEEP_MAX-1:0] k);
        logic [KEEP_MAX:0] kp;
        kp = {1'b0, k} + {{KEEP_MAX{1'b0}}, 1'b1};
        return (k != '0) && ((kp[KEEP_MAX-1:0] & k) == '0);
    endfunction

    function automatic logic [KEEP_MAX-1:0] keep_from_count(input int unsigned n,
                                                            input int unsigned w);
        logic [KEEP_MAX-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if ((i < w) && (i + n >= w)) begin
                k[i] = 1'b1;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_insert_header_mb_merge.sv
// ---------------------------------------------------------------------------
// axis_byte_merge
// Residue register plus byte-shift mux. The residue holds the bytes carried
// over from the previous beat in its low bytes; the merged word places those
// r bytes first on the wire, followed by the top W-r bytes of the new beat.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : capture the low load_cnt_i bytes of data_i as the residue
//   load_cnt_i   : number of bytes to capture on load
//   r_i          : number of valid residue bytes used by the merge
//   data_i       : incoming beat (zero when only the residue is wanted)
//   merged_o     : {residue[r bytes], data_i[top W-r bytes]}
// ---------------------------------------------------------------------------
module axis_byte_merge
    import axis_hdr_pkg::*;
#(
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [CNT_W-1:0]   load_cnt_i,
    input  logic [CNT_W-1:0]   r_i,
    input  logic [DATA_WD-1:0] data_i,
    output logic [DATA_WD-1:0] merged_o
);

    localparam int unsigned W = DATA_WD / 8;

    logic [DATA_WD-1:0] residue_q, residue_d;
    logic [DATA_WD-1:0] low_mask;
    int unsigned        sh_res, sh_in;

    // Shifts of a full bus width yield zero, which covers r = 0 and r = W
    // without special cases.
    always_comb begin
        sh_res   = 8 * (W - 32'(r_i));
        sh_in    = 8 * 32'(r_i);
        merged_o = (residue_q << sh_res) | (data_i >> sh_in);
    end

    always_comb begin
        low_mask = '0;
        for (int unsigned j = 0; j < W; j++) begin
            low_mask[8*j +: 8] = (j < 32'(load_cnt_i)) ? 8'hFF : 8'h00;
        end
        residue_d = load_i ? (data_i & low_mask) : residue_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            residue_q <= '0;
        end else begin
            residue_q <= residue_d;
        end
    end

endmodule

// File: rtl/axis_insert_header_mb.sv
// ---------------------------------------------------------------------------
// axis_insert_header_mb
// Prepends a multi-beat header stream to a payload stream, packing the bytes
// densely (MSB byte first on the wire). The first header beat contributes its
// low r bytes; every later beat is realigned by r bytes through
// axis_byte_merge. A packet whose tail does not fit one beat ends with a
// FLUSH beat carrying the leftover residue bytes.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   valid_in/data_in/keep_in/last_in  : payload stream, ready_in back-pressure
//   valid_insert/data_insert/
//   keep_insert/last_insert           : header stream, ready_insert back-pressure
//   valid_out/data_out/keep_out/
//   last_out                          : packed output stream, ready_out from sink
//   err                               : sticky protocol error, cleared by rst
//
// Handshake: a beat transfers on a rising edge where its valid and ready are
// both high. A source holds valid and its data stable until the transfer; the
// output register likewise holds valid_out and its payload until ready_out.
// ready_in/ready_insert never depend on valid_in/valid_insert.
// The FSM state is visible as state_q for debug and checkers.
// ---------------------------------------------------------------------------
module axis_insert_header_mb
    import axis_hdr_pkg::*;
#(
    parameter int unsigned DATA_WD       = 32,
    parameter int unsigned DATA_BYTE_WD  = DATA_WD / 8,
    parameter int unsigned HDR_MAX_BEATS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic                    last_insert,
    output logic                    ready_insert,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    err
);

    localparam int unsigned W      = DATA_BYTE_WD;
    localparam int unsigned CNT_W  = $clog2(W + 1);
    localparam int unsigned HCNT_W = $clog2(HDR_MAX_BEATS + 2);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    r_q, r_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [HCNT_W-1:0]   hdr_cnt_q, hdr_cnt_d;
    logic                err_q, err_d;

    logic                valid_out_q, valid_out_d;
    logic                last_out_q, last_out_d;
    logic [W-1:0]        keep_out_q, keep_out_d;
    logic [DATA_WD-1:0]  data_out_q, data_out_d;

    logic                can_adv;
    logic                rdy_ins, rdy_in;
    logic                ins_acc, pay_acc;
    logic                emit, emit_last, load;
    logic [W-1:0]        emit_keep;
    logic [CNT_W-1:0]    load_cnt, r_new;
    logic [DATA_WD-1:0]  beat_data, merged, keep_bytes;
    logic                hdr_keep_ok;
    int unsigned         r_ins, b_in, rb;

    // The output register may take a new beat when empty or draining.
    assign can_adv = !valid_out_q || ready_out;

    assign r_ins       = popcount(KEEP_MAX'(keep_insert));
    assign hdr_keep_ok = keep_lsb_contig(KEEP_MAX'(keep_insert));
    assign b_in        = popcount(KEEP_MAX'(keep_in));
    assign rb          = 32'(r_q) + b_in;
    // A malformed first-header keep is treated as a full beat.
    assign r_new       = hdr_keep_ok ? CNT_W'(r_ins) : CNT_W'(W);

    always_comb begin
        rdy_ins = 1'b0;
        rdy_in  = 1'b0;
        case (state_q)
            ST_IDLE, ST_HDR: rdy_ins = can_adv;
            ST_PAY:          rdy_in  = can_adv;
            default: begin
                rdy_ins = 1'b0;
                rdy_in  = 1'b0;
            end
        endcase
    end

    assign ready_insert = rdy_ins && !rst;
    assign ready_in     = rdy_in && !rst;
    assign ins_acc      = valid_insert && ready_insert;
    assign pay_acc      = valid_in && ready_in;

    axis_byte_merge #(
        .DATA_WD (DATA_WD),
        .CNT_W   (CNT_W)
    ) u_merge (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_cnt_i (load_cnt),
        .r_i        (r_q),
        .data_i     (beat_data),
        .merged_o   (merged)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        flush_cnt_d = flush_cnt_q;
        hdr_cnt_d   = hdr_cnt_q;
        err_d       = err_q;
        emit        = 1'b0;
        emit_last   = 1'b0;
        emit_keep   = '1;
        load        = 1'b0;
        load_cnt    = r_q;
        beat_data   = data_insert;

        case (state_q)
            ST_IDLE: begin
                if (ins_acc) begin
                    load      = 1'b1;
                    load_cnt  = r_new;
                    r_d       = r_new;
                    hdr_cnt_d = HCNT_W'(1);
                    if (!hdr_keep_ok) begin
                        err_d = 1'b1;
                    end
                    state_d = last_insert ? ST_PAY : ST_HDR;
                end
            end
            ST_HDR: begin
                if (ins_acc) begin
                    load = 1'b1;
                    emit = 1'b1;
                    if (hdr_cnt_q >= HCNT_W'(HDR_MAX_BEATS)) begin
                        // Header overran its limit: close it with this beat.
                        err_d   = 1'b1;
                        state_d = ST_PAY;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 1'b1;
                        if (last_insert) begin
                            state_d = ST_PAY;
                        end
                    end
                end
            end
            ST_PAY: begin
                beat_data = data_in;
                if (pay_acc) begin
                    load = 1'b1;
                    emit = 1'b1;
                    if (last_in) begin
                        if (rb <= W) begin
                            emit_keep = W'(keep_from_count(rb, W));
                            emit_last = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            flush_cnt_d = CNT_W'(rb - W);
                            state_d     = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                // Zero input so the merge presents the residue MSB-aligned.
                beat_data = '0;
                if (can_adv) begin
                    emit      = 1'b1;
                    emit_keep = W'(keep_from_count(32'(flush_cnt_q), W));
                    emit_last = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bytes outside keep are driven as zero.
    always_comb begin
        keep_bytes = '0;
        for (int unsigned i = 0; i < W; i++) begin
            keep_bytes[8*i +: 8] = {8{emit_keep[i]}};
        end
    end

    always_comb begin
        valid_out_d = valid_out_q;
        last_out_d  = last_out_q;
        keep_out_d  = keep_out_q;
        data_out_d  = data_out_q;
        if (can_adv) begin
            valid_out_d = emit;
            if (emit) begin
                last_out_d = emit_last;
                keep_out_d = emit_keep;
                data_out_d = merged & keep_bytes;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            flush_cnt_q <= '0;
            hdr_cnt_q   <= '0;
            err_q       <= 1'b0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
            keep_out_q  <= '0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            flush_cnt_q <= flush_cnt_d;
            hdr_cnt_q   <= hdr_cnt_d;
            err_q       <= err_d;
            valid_out_q <= valid_out_d;
            last_out_q  <= last_out_d;
            keep_out_q  <= keep_out_d;
            data_out_q  <= data_out_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign keep_out  = keep_out_q;
    assign last_out  = last_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_axis_insert_header_mb.sv
module tb_axis_insert_header_mb;

    localparam int DATA_WD = 32;
    localparam int W       = DATA_WD / 8;
    localparam int HDR_MAX = 4;
    localparam int EW      = DATA_WD + W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               valid_in, last_in, ready_in;
    logic [DATA_WD-1:0] data_in;
    logic [W-1:0]       keep_in;
    logic               valid_insert, last_insert, ready_insert;
    logic [DATA_WD-1:0] data_insert;
    logic [W-1:0]       keep_insert;
    logic               valid_out, last_out, ready_out, err;
    logic [DATA_WD-1:0] data_out;
    logic [W-1:0]       keep_out;

    axis_insert_header_mb dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .keep_in      (keep_in),
        .last_in      (last_in),
        .ready_in     (ready_in),
        .valid_insert (valid_insert),
        .data_insert  (data_insert),
        .keep_insert  (keep_insert),
        .last_insert  (last_insert),
        .ready_insert (ready_insert),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .keep_out     (keep_out),
        .last_out     (last_out),
        .ready_out    (ready_out),
        .err          (err)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic          mon_en = 1'b0;
    logic          stall_en = 1'b0;

    logic [DATA_WD-1:0] hdr_data[0:7];
    logic [W-1:0]       hdr_keep[0:7];
    int                 hdr_n;
    logic [DATA_WD-1:0] pay_data[0:15];
    logic [W-1:0]       pay_keep[0:15];
    int                 pay_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Byte k of a beat in wire order (k = 0 is first on the wire).
    function automatic logic [7:0] wire_byte(input logic [DATA_WD-1:0] d, input int k);
        return d[DATA_WD-1-8*k -: 8];
    endfunction

    // Build the packet's byte stream from the stream rules, then cut it into
    // W-byte output beats; the final beat carries last and a partial keep.
    task automatic model_push();
        logic [7:0]         bq[$];
        int                 r, b, n;
        logic [DATA_WD-1:0] d;
        logic [W-1:0]       kp;
        r = $countones(hdr_keep[0]);
        if (r == 0 || hdr_keep[0] != W'((1 << r) - 1)) r = W;
        for (int k = W - r; k < W; k++) bq.push_back(wire_byte(hdr_data[0], k));
        for (int i = 1; i < hdr_n; i++)
            for (int k = 0; k < W; k++) bq.push_back(wire_byte(hdr_data[i], k));
        for (int i = 0; i < pay_n; i++) begin
            b = (i == pay_n - 1) ? $countones(pay_keep[i]) : W;
            for (int k = 0; k < b; k++) bq.push_back(wire_byte(pay_data[i], k));
        end
        while (bq.size() > 0) begin
            n  = (bq.size() < W) ? bq.size() : W;
            d  = '0;
            kp = '0;
            for (int j = 0; j < n; j++) begin
                d[DATA_WD-1-8*j -: 8] = bq.pop_front();
                kp[W-1-j] = 1'b1;
            end
            exp_q.push_back({(bq.size() == 0), kp, d});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_hs(input int which, output logic ok);
        logic hs;
        int   cyc;
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 2000) begin
            @(negedge clk);
            hs = (which == 0) ? ready_insert : ready_in;
            @(posedge clk);
            #1;
            cyc++;
            if (hs) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_%0d: no ready within %0d cycles, want ready", which, cyc);
        end
    endtask

    task automatic drive_hdr();
        logic ok;
        for (int i = 0; i < hdr_n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_insert = 1'b0;
                @(posedge clk);
                #1;
            end
            data_insert  = hdr_data[i];
            keep_insert  = hdr_keep[i];
            last_insert  = (i == hdr_n - 1);
            valid_insert = 1'b1;
            wait_hs(0, ok);
            if (!ok) break;
        end
        valid_insert = 1'b0;
        last_insert  = 1'b0;
    endtask

    // Payload valid is raised straight away, so it also sits against the
    // header phase and must be held off rather than lost.
    task automatic drive_pay();
        logic ok;
        for (int i = 0; i < pay_n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_in = 1'b0;
                @(posedge clk);
                #1;
            end
            data_in  = pay_data[i];
            keep_in  = pay_keep[i];
            last_in  = (i == pay_n - 1);
            valid_in = 1'b1;
            wait_hs(1, ok);
            if (!ok) break;
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic send_packet(input logic use_model);
        if (use_model) model_push();
        fork
            drive_hdr();
            drive_pay();
        join
    endtask

    task automatic rand_packet();
        int r, b;
        hdr_n = $urandom_range(1, HDR_MAX);
        r     = $urandom_range(1, W);
        for (int i = 0; i < hdr_n; i++) begin
            hdr_data[i] = $urandom();
            hdr_keep[i] = '1;
        end
        hdr_keep[0] = W'((1 << r) - 1);
        pay_n = $urandom_range(1, 6);
        for (int i = 0; i < pay_n; i++) begin
            pay_data[i] = $urandom();
            pay_keep[i] = '1;
        end
        b = $urandom_range(0, W);
        pay_keep[pay_n-1] = W'(((1 << b) - 1) << (W - b));
        send_packet(1'b1);
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_outstanding", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- sink ready generator ----------------
    initial begin
        int gap, len;
        ready_out = 1'b1;
        forever begin
            gap = $urandom_range(6, 15);
            repeat (gap) begin
                @(posedge clk);
                #1;
                ready_out = 1'b1;
            end
            if (stall_en) begin
                len = $urandom_range(1, 3);
                repeat (len) begin
                    @(posedge clk);
                    #1;
                    ready_out = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] beat, prev_beat, e;
        logic          prev_stall;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            beat = {last_out, keep_out, data_out};
            if (mon_en) begin
                if (prev_stall) check("hold_stable", 64'({valid_out, beat}), 64'({1'b1, prev_beat}));
                if (valid_out && ready_out) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL out_beat: got %h, want no beat", beat);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", 64'(beat), 64'(e));
                    end
                end
                prev_stall = valid_out && !ready_out;
                prev_beat  = beat;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic ok;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_insert = 1'b0; data_insert = '0; keep_insert = '0; last_insert = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", 64'(valid_out), 64'(0));
        check("rst_data_out", 64'(data_out), 64'(0));
        check("rst_keep_out", 64'(keep_out), 64'(0));
        check("rst_last_out", 64'(last_out), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_ready_in", 64'(ready_in), 64'(0));
        check("rst_ready_insert", 64'(ready_insert), 64'(0));
        rst = 1'b0;
        #1;
        check("idle_ready_insert", 64'(ready_insert), 64'(1));
        check("idle_ready_in", 64'(ready_in), 64'(0));
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // 3-byte header, two full payload beats -> FLUSH of three bytes
        hdr_n = 1; hdr_data[0] = 32'h00AABBCC; hdr_keep[0] = 4'b0111;
        pay_n = 2;
        pay_data[0] = 32'h11223344; pay_keep[0] = 4'b1111;
        pay_data[1] = 32'h55667788; pay_keep[1] = 4'b1111;
        exp_q.push_back({1'b0, 4'b1111, 32'hAABBCC11});
        exp_q.push_back({1'b0, 4'b1111, 32'h22334455});
        exp_q.push_back({1'b1, 4'b1110, 32'h66778800});
        send_packet(1'b0);
        drain();

        // 2-beat header (1 + 4 bytes), payload of 2 bytes
        hdr_n = 2;
        hdr_data[0] = 32'h000000A1; hdr_keep[0] = 4'b0001;
        hdr_data[1] = 32'hB1B2B3B4; hdr_keep[1] = 4'b1111;
        pay_n = 1; pay_data[0] = 32'hC1C2C3C4; pay_keep[0] = 4'b1100;
        exp_q.push_back({1'b0, 4'b1111, 32'hA1B1B2B3});
        exp_q.push_back({1'b1, 4'b1110, 32'hB4C1C200});
        send_packet(1'b0);
        drain();

        // full first header beat, payload tail of one byte -> FLUSH keep 1000
        hdr_n = 1; hdr_data[0] = 32'hD0D1D2D3; hdr_keep[0] = 4'b1111;
        pay_n = 1; pay_data[0] = 32'hE0E1E2E3; pay_keep[0] = 4'b1000;
        exp_q.push_back({1'b0, 4'b1111, 32'hD0D1D2D3});
        exp_q.push_back({1'b1, 4'b1000, 32'hE0000000});
        send_packet(1'b0);
        drain();

        // last payload beat with empty keep closes with the residue
        hdr_n = 1; hdr_data[0] = 32'h5555C0C1; hdr_keep[0] = 4'b0011;
        pay_n = 2;
        pay_data[0] = 32'h11111111; pay_keep[0] = 4'b1111;
        pay_data[1] = 32'hDEADBEEF; pay_keep[1] = 4'b0000;
        exp_q.push_back({1'b0, 4'b1111, 32'hC0C11111});
        exp_q.push_back({1'b1, 4'b1100, 32'h11110000});
        send_packet(1'b0);
        drain();
        check("err_clean", 64'(err), 64'(0));

        // non-contiguous first keep: error, whole beat taken as header
        hdr_n = 1; hdr_data[0] = 32'h12345678; hdr_keep[0] = 4'b0101;
        pay_n = 1; pay_data[0] = 32'h9ABCDEF0; pay_keep[0] = 4'b1111;
        exp_q.push_back({1'b0, 4'b1111, 32'h12345678});
        exp_q.push_back({1'b1, 4'b1111, 32'h9ABCDEF0});
        send_packet(1'b0);
        drain();
        check("err_set", 64'(err), 64'(1));

        // random packets, sink always ready
        for (int p = 0; p < 20; p++) rand_packet();
        drain();

        // random packets with sink stalls
        stall_en = 1'b1;
        for (int p = 0; p < 30; p++) rand_packet();
        drain();
        stall_en = 1'b0;
        check("err_sticky", 64'(err), 64'(1));

        // reset in the middle of a payload
        mon_en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        data_insert = 32'h01020304; keep_insert = 4'b1111; last_insert = 1'b1;
        valid_insert = 1'b1;
        wait_hs(0, ok);
        valid_insert = 1'b0; last_insert = 1'b0;
        data_in = 32'hA5A5A5A5; keep_in = 4'b1111; last_in = 1'b0; valid_in = 1'b1;
        wait_hs(1, ok);
        rst = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("midrst_valid_out", 64'(valid_out), 64'(0));
        check("midrst_data_out", 64'(data_out), 64'(0));
        check("midrst_keep_out", 64'(keep_out), 64'(0));
        check("midrst_last_out", 64'(last_out), 64'(0));
        check("midrst_err", 64'(err), 64'(0));
        check("midrst_ready_in", 64'(ready_in), 64'(0));
        check("midrst_ready_insert", 64'(ready_insert), 64'(0));
        rst = 1'b0;
        #1;
        check("postrst_ready_insert", 64'(ready_insert), 64'(1));
        exp_q.delete();
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        for (int p = 0; p < 3; p++) rand_packet();
        drain();
        check("postrst_err", 64'(err), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_insert_header_mb.md
AXIS_INSERT_HEADER_MB -- requirements
Module: axis_insert_header_mb

Interface
REQ-001 Parameter DATA_WD, default 32, data bus width in bits; SHALL be a multiple of 8, minimum 16.
REQ-002 Parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat (W below).
REQ-003 Parameter HDR_MAX_BEATS, default 4, maximum header beats per packet.
REQ-004 Ports SHALL be:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  payload beat valid.
- data_in  in  DATA_WD  payload data; MSB byte is first on the wire.
- keep_in  in  W  payload byte enables; MSB-aligned contiguous; all-ones except on the last beat.
- last_in  in  1  last payload beat.
- ready_in  out  1  payload accepted when valid_in && ready_in.
- valid_insert  in  1  header beat valid.
- data_insert  in  DATA_WD  header data.
- keep_insert  in  W  header byte enables; LSB-aligned contiguous on the first header beat, all-ones on later beats.
- last_insert  in  1  last header beat.
- ready_insert  out  1  header accepted when valid_insert && ready_insert.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WD  header bytes followed by payload bytes, MSB-first, densely packed.
- keep_out  out  W  MSB-aligned contiguous; all-ones except on the last beat.
- last_out  out  1  last output beat.
- ready_out  in  1  downstream ready.
- err  out  1  sticky protocol-error flag.

Function
REQ-005 States SHALL be: IDLE, HDR, PAY, FLUSH.
REQ-006 In IDLE, ready_insert SHALL be 1 and ready_in SHALL be 0.
REQ-007 In IDLE, on header accept: r := popcount(keep_insert), range 1..W; residue := the low r bytes of data_insert.
REQ-008 From IDLE, the next state SHALL be PAY if last_insert, else HDR.
REQ-009 For every beat accepted in HDR or PAY, out data SHALL be residue[r bytes] concatenated with the top W-r bytes of the input; residue := the low r bytes of the input.
- With r = W, out data is the residue and residue := the whole input.
REQ-010 In HDR, ready_insert SHALL be asserted and ready_in SHALL be 0.
REQ-011 On a last_insert beat in HDR, the next state SHALL be PAY.
REQ-012 In PAY, ready_in SHALL be asserted and ready_insert SHALL be 0.
REQ-013 On a PAY last beat with b = popcount(keep_in) valid bytes:
- If r+b <= W: emit one beat, keep_out = top r+b ones, last_out=1; return to IDLE.
- Else: emit a full beat with last_out=0; go to FLUSH.
REQ-014 In FLUSH, the block SHALL emit residue bytes r+b-W with matching keep_out and last_out=1, then return to IDLE. ready_in and ready_insert SHALL be 0 in FLUSH.
REQ-015 The output SHALL be a single register stage.
- Input readiness gated by (!valid_out || ready_out).
- valid_out held stable with data until ready_out.
- Latency: one cycle from accept to valid_out.
REQ-016 Throughput SHALL be one beat per cycle in steady state with ready_out=1.
- Header-to-payload and back-to-back packets incur no bubble, except one FLUSH beat when r+b > W.
REQ-017 When HDR beat count exceeds HDR_MAX_BEATS, err SHALL set and the state SHALL go to PAY on the next accepted beat.
REQ-018 When keep_insert is zero or non-contiguous on the first header beat, err SHALL set and r SHALL be forced to W.
REQ-019 err SHALL clear only on rst.
REQ-020 A payload beat with last_in and keep_in zero SHALL be treated as b=0: close the packet with the residue as the last beat.
REQ-021 valid_in asserted while in IDLE or HDR SHALL be back-pressured, never dropped.

Reset
REQ-022 While rst=1, all state SHALL clear next edge: state=IDLE, valid_out=0, last_out=0, keep_out=0, data_out=0, err=0, residue=0, r=0.
REQ-023 During reset, ready_in and ready_insert SHALL be 0.
REQ-024 Reset mid-packet SHALL abandon the packet; the first post-reset accepted header beat starts a new packet.

Structure
REQ-025 A shared package axis_hdr_pkg SHALL hold:
- the state enum;
- popcount and keep-contiguity check functions;
- a keep-from-count function.
REQ-026 Byte merge and shift SHALL be a sub-module axis_byte_merge (residue register plus r-shift mux); the FSM and output register stay in the top.

Verification (W=4)
REQ-027 Header 1 beat, keep_insert=0111, data 0x00AABBCC; payload 2 full beats 0x11223344, 0x55667788 -> out 0xAABBCC11, 0x22334455, then 0x667788xx with keep 1110, last.
REQ-028 Header 2 beats (keep 0001, then 1111); payload 1 beat with keep 1100 -> 2 out beats, second keep 1110, last; verify byte order.
REQ-029 keep_insert=1111 with payload last keep 1000 -> FLUSH beat with keep 1000, last_out=1.
REQ-030 Random ready_out stalls every 6-15 cycles -> byte stream identical to the no-stall reference model; data_out stable while valid_out && !ready_out.
REQ-031 keep_insert=0101 -> err=1 sticky, r=4 behaviour; subsequent packet still correct.
REQ-032 rst pulsed mid-PAY -> outputs zero next cycle; the following packet is correct.
